// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store sequencer with read-modify-write for sub-word stores
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         CPU request handshake (ready only in IDLE)
//   req_we, req_funct3          1=store/0=load; size and sign (B,H,W,BU,HU)
//   req_addr, req_wdata         byte address; right-justified store data
//   resp_valid/rdata/error      one-cycle completion pulse, load result, error flag
//   mem_we/addr/wdata, mem_rdata  word-wide memory, combinational read, write on clk edge
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
    state_t      r_state, w_next;
    logic        r_we, r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_result, r_merge;
    logic        w_accept, w_err;
    logic [4:0]  w_shamt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load, w_mask, w_merged;
    assign req_ready = r_state == IDLE;
    assign w_accept  = req_valid && req_ready;
    // illegal encodings, sub-word stores with unsigned encodings, and misalignment
    assign w_err = (req_funct3 == 3'b011) || (req_funct3[2] && (req_we || req_funct3[1])) ||
                   (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
    assign w_shamt  = {r_addr[1:0], 3'b000};
    assign w_byte   = 8'(mem_rdata >> w_shamt);
    assign w_half   = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] marks the unsigned variants; word loads pass through untouched
    assign w_load   = r_f3[1] ? mem_rdata :
                      r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half} :
                                {{24{~r_f3[2] & w_byte[7]}}, w_byte};
    // halves are known aligned here, so the byte shift also places the half lane
    assign w_mask   = (r_f3[0] ? 32'h0000_ffff : 32'h0000_00ff) << w_shamt;
    assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = w_err ? RESP : !req_we ? LOAD : req_funct3[1] ? WRITE : RMW_READ;
            LOAD:     w_next = RESP;
            RMW_READ: w_next = WRITE;
            WRITE:    w_next = RESP;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_f3     <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_result <= 32'h0;
            r_merge  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_err;
            end
            if (r_state == LOAD) r_result <= w_load;
            if (r_state == RMW_READ) r_merge <= w_merged;
        end
    end
    assign resp_valid = r_state == RESP;
    assign resp_error = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_we && !r_err) ? r_result : 32'h0;
    // a reset arriving during WRITE must cancel the write at that same edge
    assign mem_we     = (r_state == WRITE) && !rst;
    assign mem_addr   = (r_state == IDLE) ? 32'h0 : {r_addr[31:2], 2'b00};
    assign mem_wdata  = (r_state == WRITE) ? (r_f3[1] ? r_wdata : r_merge) : 32'h0;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  CPU access request.
REQ-004 SHALL have: req_ready  out  1  unit can accept a request.
REQ-005 SHALL have: req_we  in  1  1=store, 0=load.
REQ-006 SHALL have: req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 SHALL have: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-008 SHALL have: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  load result; resp_error  out  1  misaligned or illegal access.
REQ-009 SHALL have: mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32; these drive the word-wide data memory, which has a combinational read and writes on the clk edge when mem_we=1.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-011 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid&req_ready, latching we, funct3, addr and wdata.
REQ-012 SHALL flag an error at acceptance when: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-013 SHALL transition from IDLE on acceptance to: RESP if error; LOAD if load; WRITE if SW; RMW_READ if SB/SH.
REQ-014 SHALL, outside IDLE, drive mem_addr = {latched_addr[31:2],2'b00}; in IDLE mem_addr=0.
REQ-015 SHALL, in LOAD, extract the lane from mem_rdata (little-endian: byte n = bits 8n+7:8n, half = byte addr[1]), then sign-extend (B/H) or zero-extend (BU/HU/W) into a result register; next state RESP.
REQ-016 SHALL, in RMW_READ, capture mem_rdata, replace only the addressed byte/half lane with req_wdata[7:0]/[15:0], and store the merged word; next state WRITE.
REQ-017 SHALL, in WRITE, drive mem_we=1 and mem_wdata = merged word (SB/SH) or latched wdata (SW) for exactly one cycle; next state RESP.
REQ-018 SHALL drive mem_we=0 and mem_wdata=0 in every state other than WRITE.
REQ-019 SHALL, in RESP, assert resp_valid for exactly one cycle with resp_rdata = result (loads, no error) else 0, and resp_error = latched error; next state IDLE.
REQ-020 SHALL never touch memory (no mem_we) for an errored request.
REQ-021 Latency, acceptance edge = cycle 0: resp_valid in cycle 2 for loads/SW/errors (errors: cycle 1), cycle 3 for SB/SH.
REQ-022 SHALL ignore req_valid and all req_* inputs while not in IDLE; there is no response backpressure.
REQ-023 SHALL accept a new request in the first IDLE cycle following RESP (back-to-back throughput: one access per 3-4 cycles).

Reset
REQ-024 SHALL, with rst=1 at an edge, enter IDLE and clear result, merge and error registers; resp_valid, resp_error, resp_rdata, mem_we, mem_wdata, mem_addr = 0 and req_ready=1 after the edge.
REQ-025 SHALL gate mem_we with !rst so that rst asserted during WRITE suppresses the memory write at that edge.
REQ-026 SHALL give rst priority over request acceptance in the same cycle (request dropped).

Verification
REQ-027 mem word 0x2000=0x00ff00ff; LB 0x2000 -> resp_rdata 0xFFFFFFFF; LBU 0x2000 -> 0x000000FF; LB 0x2001 -> 0x00000000, each resp_valid in cycle 2.
REQ-028 mem word 0x2004=0xff00ff00; LH 0x2006 -> 0xFFFFFF00; LHU 0x2006 -> 0x0000FF00; LW 0x2004 -> 0xFF00FF00.
REQ-029 SB addr 0x2002 wdata 0x123456AB on 0x00ff00ff -> single mem_we pulse cycle 2, mem_addr 0x2000, mem_wdata 0x00AB00FF; resp_valid cycle 3; following LW 0x2000 -> 0x00AB00FF.
REQ-030 LW 0x2002, SH 0x2001, load funct3=011 -> resp_error=1, resp_rdata=0, resp_valid cycle 1, no mem_we at any point.
REQ-031 SW 0x2008 wdata 0xDEADBEEF with rst=1 during WRITE -> no write (LW 0x2008 afterwards returns 0x0ff00ff0), no resp_valid, req_ready=1 next cycle.
REQ-032 req_valid held high continuously with alternating LW/SW -> each request accepted only in IDLE, exactly one resp_valid per accepted request, req_* changes while busy have no effect.
